// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: frame constants and FSM states shared by the AES SPI master and slave
package aes_spi_pkg;
  localparam int PT_BITS = 128;
  localparam int CT_BITS = 128;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE} spi_state_e;
  function automatic int key_bits(input int nk);
    return 32 * nk;
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter ticking every CLK_DIV cycles, restarted by clr
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI mode-0 initiator sending plaintext+key and reading back ciphertext
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int Nk      = 4,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      data_in,
  input  logic [32*Nk-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic [127:0]      data_out,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);
  localparam int TX_BITS = PT_BITS + key_bits(Nk);
  localparam int TOTAL   = TX_BITS + CT_BITS;
  localparam int KW      = $clog2(TOTAL + 1);
  spi_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TX_BITS-1:0] tx_q, tx_d;
  logic [CT_BITS-1:0] rx_q, rx_d, data_out_q, data_out_d;
  logic mosi_q, mosi_d, sclk_q, sclk_d, cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d;
  logic tick;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .tick (tick)
  );
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    mosi_d     = mosi_q;
    busy_d     = done_q ? 1'b0 : busy_q;
    done_d     = state_q == DONE;
    data_out_d = state_q == DONE ? rx_q : data_out_q;
    case (state_q)
      IDLE: if (start && !busy_q) begin
        state_d = SETUP;
        tx_d    = {data_in, key_in};
        k_d     = '0;
        mosi_d  = data_in[127];
        busy_d  = 1'b1;
      end
      SETUP: if (tick) state_d = SHIFT_HI;
      // falling sclk edge: advance to the next bit; zeros shifted in become the readback mosi
      SHIFT_HI: if (tick) begin
        state_d = SHIFT_LO;
        tx_d    = tx_q << 1;
        mosi_d  = tx_q[TX_BITS-2];
        k_d     = k_q + 1'b1;
      end
      SHIFT_LO: if (tick) begin
        state_d = k_q < KW'(TOTAL) ? SHIFT_HI : HOLD;
        if (k_q < KW'(TOTAL) && k_q >= KW'(TX_BITS)) rx_d = {rx_q[CT_BITS-2:0], miso};
      end
      HOLD: if (tick) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sclk_d = state_d == SHIFT_HI;
    cs_n_d = state_d == IDLE || state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;
endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: directed checks of two master instances against behavioural SPI slaves
module tb_aes_spi_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start_a = 1'b0, busy_a, done_a, sclk_a, cs_n_a, mosi_a, miso_a;
  logic [127:0] pt_a = '0, key_a = '0, dout_a;
  logic start_b = 1'b0, busy_b, done_b, sclk_b, cs_n_b, mosi_b, miso_b;
  logic [127:0] pt_b = '0, dout_b;
  logic [255:0] key_b = '0;
  int cmps = 0, errs = 0;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FK4 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FC4 = 128'h69c4e0d86b7b0430d8cdb78070b4c55a;
  localparam logic [255:0] FK8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FC8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BPT = 128'h80000000000000000000000000000001;
  localparam logic [127:0] BCT = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_spi_master #(.Nk(4), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(pt_a), .key_in(key_a),
    .busy(busy_a), .done(done_a), .data_out(dout_a),
    .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a));
  aes_spi_master #(.Nk(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(pt_b), .key_in(key_b),
    .busy(busy_b), .done(done_b), .data_out(dout_b),
    .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b));

  int a_cnt = 0, a_dones = 0, a_csfalls = 0;
  logic [383:0] a_cap = '0;
  logic [127:0] a_ct = '0, a_sh = '0;
  logic a_miso = 1'b0, tog = 1'b0;
  assign miso_a = a_miso ^ tog;
  always @(posedge sclk_a or negedge cs_n_a)
    if (!sclk_a) begin a_cnt = 0; a_cap = '0; end
    else begin a_cap = {a_cap[382:0], mosi_a}; a_cnt++; end
  always @(negedge sclk_a)
    if (a_cnt == 256) begin a_miso = a_ct[127]; a_sh = a_ct << 1; end
    else if (a_cnt > 256 && a_cnt < 384) begin a_miso = a_sh[127]; a_sh = a_sh << 1; end
    else a_miso = 1'b0;
  always @(negedge clk) if (done_a) a_dones++;
  always @(negedge cs_n_a) a_csfalls++;

  int b_cnt = 0;
  logic [511:0] b_cap = '0;
  logic [127:0] b_ct = '0, b_sh = '0;
  logic b_miso = 1'b0;
  assign miso_b = b_miso;
  always @(posedge sclk_b or negedge cs_n_b)
    if (!sclk_b) begin b_cnt = 0; b_cap = '0; end
    else begin b_cap = {b_cap[510:0], mosi_b}; b_cnt++; end
  always @(negedge sclk_b)
    if (b_cnt == 384) begin b_miso = b_ct[127]; b_sh = b_ct << 1; end
    else if (b_cnt > 384 && b_cnt < 512) begin b_miso = b_sh[127]; b_sh = b_sh << 1; end
    else b_miso = 1'b0;

  task automatic run_a(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                       output int lat, output bit to);
    a_ct = ct;
    @(negedge clk);
    pt_a = pt; key_a = key; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 5000) begin @(posedge clk); #1 lat++; end
    to = !done_a;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    cmps++; if (cs_n_a !== 1'b1) begin errs++; $display("FAIL reset_cs_n got %b want 1", cs_n_a); end
    cmps++; if (sclk_a !== 1'b0) begin errs++; $display("FAIL reset_sclk got %b want 0", sclk_a); end
    cmps++; if (mosi_a !== 1'b0) begin errs++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
    cmps++; if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy_a); end
    cmps++; if (done_a !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done_a); end
    cmps++; if (dout_a !== '0) begin errs++; $display("FAIL reset_data_out got %h want 0", dout_a); end
    cmps++; if (cs_n_b !== 1'b1) begin errs++; $display("FAIL reset_cs_n_b got %b want 1", cs_n_b); end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    int d0 = a_dones;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); tog = ~tog;
      cmps++;
      if ({done_a, busy_a, sclk_a, mosi_a, cs_n_a} !== 5'b00001) begin
        errs++; $display("FAIL idle_outputs cycle %0d got %b want 00001", i, {done_a, busy_a, sclk_a, mosi_a, cs_n_a});
      end
    end
    tog = 1'b0;
    cmps++; if (dout_a !== '0) begin errs++; $display("FAIL idle_data_out got %h want 0", dout_a); end
    cmps++; if (a_dones != d0) begin errs++; $display("FAIL idle_done_count got %0d want %0d", a_dones, d0); end
  endtask

  task automatic test_fips128;
    int lat, d0 = a_dones;
    bit to;
    run_a(FPT, FK4, FC4, lat, to);
    cmps++; if (to) begin errs++; $display("FAIL fips128_timeout got no done want done"); end
    cmps++; if (lat != 1541) begin errs++; $display("FAIL fips128_latency got %0d want 1541", lat); end
    cmps++; if (dout_a !== FC4) begin errs++; $display("FAIL fips128_data_out got %h want %h", dout_a, FC4); end
    cmps++; if ({busy_a, cs_n_a} !== 2'b11) begin errs++; $display("FAIL fips128_done_cycle busy,cs_n got %b want 11", {busy_a, cs_n_a}); end
    cmps++; if (a_cap !== {FPT, FK4, 128'h0}) begin errs++; $display("FAIL fips128_mosi got %h want %h", a_cap, {FPT, FK4, 128'h0}); end
    @(posedge clk); #1;
    cmps++; if ({done_a, busy_a, sclk_a} !== 3'b000) begin errs++; $display("FAIL fips128_after done,busy,sclk got %b want 000", {done_a, busy_a, sclk_a}); end
    cmps++; if (dout_a !== FC4) begin errs++; $display("FAIL fips128_hold got %h want %h", dout_a, FC4); end
    cmps++; if (a_dones - d0 != 1) begin errs++; $display("FAIL fips128_done_pulses got %0d want 1", a_dones - d0); end
  endtask

  task automatic test_bit_order;
    int lat;
    bit to;
    run_a(BPT, '1, BCT, lat, to);
    cmps++; if (to) begin errs++; $display("FAIL bitorder_timeout got no done want done"); end
    cmps++; if (a_cap !== {BPT, {128{1'b1}}, 128'h0}) begin errs++; $display("FAIL bitorder_mosi got %h want %h", a_cap, {BPT, {128{1'b1}}, 128'h0}); end
    cmps++; if (a_cnt != 384) begin errs++; $display("FAIL bitorder_edges got %0d want 384", a_cnt); end
    cmps++; if (dout_a !== BCT) begin errs++; $display("FAIL bitorder_data_out got %h want %h", dout_a, BCT); end
    @(posedge clk); #1;
    cmps++; if (busy_a !== 1'b0) begin errs++; $display("FAIL bitorder_busy_after got %b want 0", busy_a); end
  endtask

  task automatic test_nk8;
    int lat = 0;
    b_ct = FC8;
    @(negedge clk);
    pt_b = FPT; key_b = FK8; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    while (!done_b && lat < 5000) begin @(posedge clk); #1 lat++; end
    cmps++; if (!done_b) begin errs++; $display("FAIL nk8_timeout got no done want done"); end
    cmps++; if (lat != 1027) begin errs++; $display("FAIL nk8_latency got %0d want 1027", lat); end
    cmps++; if (dout_b !== FC8) begin errs++; $display("FAIL nk8_data_out got %h want %h", dout_b, FC8); end
    cmps++; if (b_cnt != 512) begin errs++; $display("FAIL nk8_edges got %0d want 512", b_cnt); end
    cmps++; if (b_cap !== {FPT, FK8, 128'h0}) begin errs++; $display("FAIL nk8_mosi got %h want %h", b_cap, {FPT, FK8, 128'h0}); end
    @(posedge clk); #1;
    cmps++; if ({done_b, busy_b, cs_n_b} !== 3'b001) begin errs++; $display("FAIL nk8_after done,busy,cs_n got %b want 001", {done_b, busy_b, cs_n_b}); end
  endtask

  task automatic test_start_while_busy;
    int n = 0, lat, f0 = a_csfalls, d0 = a_dones;
    bit to;
    a_ct = FC4;
    @(negedge clk);
    pt_a = FPT; key_a = FK4; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (!done_a && n < 5000) begin
      @(posedge clk); #1 n++;
      start_a = (n == 10 || n == 500);
    end
    start_a = 1'b0;
    cmps++; if (!done_a) begin errs++; $display("FAIL busy_start_timeout got no done want done"); end
    cmps++; if (n != 1541) begin errs++; $display("FAIL busy_start_latency got %0d want 1541", n); end
    cmps++; if (dout_a !== FC4) begin errs++; $display("FAIL busy_start_data_out got %h want %h", dout_a, FC4); end
    cmps++; if (a_csfalls - f0 != 1) begin errs++; $display("FAIL busy_start_frames got %0d want 1", a_csfalls - f0); end
    @(posedge clk); #1;
    cmps++; if (a_dones - d0 != 1) begin errs++; $display("FAIL busy_start_dones got %0d want 1", a_dones - d0); end
    cmps++; if ({busy_a, cs_n_a} !== 2'b01) begin errs++; $display("FAIL busy_start_idle busy,cs_n got %b want 01", {busy_a, cs_n_a}); end
    a_ct = BCT; pt_a = BPT; key_a = '1; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cmps++; if ({busy_a, cs_n_a} !== 2'b10) begin errs++; $display("FAIL restart_accept busy,cs_n got %b want 10", {busy_a, cs_n_a}); end
    lat = 0;
    while (!done_a && lat < 5000) begin @(posedge clk); #1 lat++; end
    to = !done_a;
    cmps++; if (to || dout_a !== BCT) begin errs++; $display("FAIL restart_data_out got %h (timeout %0d) want %h", dout_a, to, BCT); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n = 0, lat, d0 = a_dones;
    bit to;
    a_ct = FC4;
    @(negedge clk);
    pt_a = FPT; key_a = FK4; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (a_cnt < 200 && n < 5000) begin @(negedge clk); n++; end
    cmps++; if (a_cnt != 200) begin errs++; $display("FAIL rstmid_reach got %0d want 200", a_cnt); end
    #2 rst = 1'b1;
    #1;
    cmps++; if ({cs_n_a, sclk_a, mosi_a, busy_a, done_a} !== 5'b10000) begin errs++; $display("FAIL rstmid_outputs cs_n,sclk,mosi,busy,done got %b want 10000", {cs_n_a, sclk_a, mosi_a, busy_a, done_a}); end
    cmps++; if (dout_a !== '0) begin errs++; $display("FAIL rstmid_data_out got %h want 0", dout_a); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmps++; if (a_dones != d0) begin errs++; $display("FAIL rstmid_no_done got %0d want %0d", a_dones, d0); end
    run_a(FPT, FK4, FC4, lat, to);
    cmps++; if (to || lat != 1541) begin errs++; $display("FAIL rstmid_rerun_latency got %0d (timeout %0d) want 1541", lat, to); end
    cmps++; if (dout_a !== FC4) begin errs++; $display("FAIL rstmid_rerun_data_out got %h want %h", dout_a, FC4); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_idle;
    test_fips128;
    test_bit_order;
    test_nk8;
    test_start_while_busy;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
- SPI mode-0 initiator that feeds the AES SPI slave, i.e. the host end of the same link.
- On start: asserts cs_n, shifts out 128 plaintext bits then 32*Nk key bits on mosi, then clocks 128 ciphertext bits back in on miso.
- Presents the ciphertext on a parallel port with a done pulse.
- Sits between a host/test controller and the off-chip or on-chip AES slave.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8); must match the slave.
- CLK_DIV, 2, clk cycles per sclk half-period; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- data_in  in  128  plaintext; latched on start acceptance
- key_in  in  32*Nk  key; latched on start acceptance
- busy  out  1  high from start acceptance until the done cycle (inclusive)
- done  out  1  one-cycle pulse; data_out is valid this cycle
- data_out  out  128  received ciphertext; held until the next done
- sclk  out  1  SPI clock, idle low
- cs_n  out  1  chip select, active low, idle high
- mosi  out  1  serial data to slave
- miso  in  1  serial data from slave

Behaviour:
- Reset (async, rst=1): cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_out=0, FSM=IDLE, counters=0. Reset mid-transfer aborts immediately; no done.
- Frame definition:
  - TX_BITS = 128 + 32*Nk; TOTAL = TX_BITS + 128.
  - Bit k, 0..TOTAL-1: k<128 is plaintext MSB-first; 128≤k<TX_BITS is key MSB-first; k≥TX_BITS is readback, with mosi held 0.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, DONE.
- IDLE:
  - start=1 latches data_in and key_in into a TX_BITS shift register.
  - Sets cs_n=0, busy=1, mosi=bit 0 (data_in[127]), bit counter=0 → SETUP.
  - start while busy is ignored.
- SETUP: CLK_DIV cycles, sclk=0 → SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles.
  - On entry (the sclk rising edge) miso is sampled; if k≥TX_BITS it shifts into rx register LSB end, so the first readback bit ends at data_out[127].
  - → SHIFT_LO.
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles.
  - On entry, mosi updates to bit k+1 (0 in readback) and k increments.
  - After CLK_DIV cycles → SHIFT_HI if k<TOTAL, else HOLD.
- HOLD: CLK_DIV cycles, sclk=0, cs_n still 0 → DONE.
- DONE (one cycle): cs_n=1, done=1, data_out=rx, busy=1 this cycle → IDLE. busy=0 next cycle; a new start is accepted the cycle after DONE.
- Latency: done asserts exactly CLK_DIV*(2*TOTAL+2)+1 cycles after the start-accepting edge. For Nk=4, CLK_DIV=2 that is 1541.
- Widths:
  - bit counter ceil(log2(TOTAL+1)) bits.
  - divider counter ceil(log2(CLK_DIV+1)) bits.
  - No overflow possible.
- sclk, cs_n and mosi come directly from flops (glitch-free).
- miso is sampled in clk domain; the slave must be clocked from this sclk or be synchronous with margin of ≥1 clk.

Decomposition:
- Shared package aes_spi_pkg:
  - constants PT_BITS=128, CT_BITS=128.
  - function key_bits(Nk)=32*Nk.
  - FSM state enum.
  - used also by the slave.
- One natural sub-module: spi_clk_div (half-period counter producing a tick every CLK_DIV cycles, with sync clear on state entry). All other logic stays in aes_spi_master.

Test Plan:
- FIPS-197 vector, loopback with behavioural slave returning the cipher:
  - stimulus: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, Nk=4.
  - response: data_out=69c4e0d86b7b0430d8cdb78070b4c55a; done at cycle 1541 (CLK_DIV=2).
- Bit-order check:
  - stimulus: pt=8000…0001, key=all-ones.
  - response: mosi captured at sclk rising edges shows 1, then 126 zeros, then 1, then 128 ones, then 128 zeros.
- Nk=8, CLK_DIV=1 vector:
  - stimulus: pt=00112233…eeff, key=000102…1f.
  - response: data_out=8ea2b7ca516745bfeafc49904b496089; 512 sclk rising edges per frame.
- Start while busy:
  - stimulus: start pulsed at cycles 10 and 500 of a transfer.
  - response: single frame, one done, cs_n low once.
  - a start in the cycle after done begins a new frame.
- Reset mid-transfer:
  - stimulus: rst asserted at bit 200.
  - response: cs_n=1, sclk=0, mosi=0, busy=0, data_out=0 without a clk edge; no done.
  - a subsequent start gives correct ciphertext.
- Idle behaviour:
  - stimulus: no start for 100 cycles after reset.
  - response: cs_n=1, sclk=0, mosi=0, busy=0, done never asserted; miso toggling has no effect on data_out.
